uart_rx_ram_loader: RTL and testbench

UART receiver for the character RAM. It deserializes 8N1 frames from the host terminal line, keeps the low 7 bits (ASCII), and produces one-cycle write strobes to the 40x7 character RAM at consecutive addresses starting from 0. It exports the running character count, so the send path can later replay exactly what was typed.

---
 rtl/uart_rx_ram_loader.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_ram_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ram_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_ram_loader: 8N1 UART receiver loading 7-bit characters into RAM   |
// | Optional 8E1 with ParityError via `define UART_RX_PARITY_EN. Rev 1.0      |
// +--------------------------------------------------------------------------+
module uart_rx_ram_loader #(
  parameter int CLOCK_HZ     = 70000000,
  parameter int BAUD         = 9600,
  parameter int DEPTH        = 40,
  parameter int CLKS_PER_BIT = CLOCK_HZ / BAUD
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       rx,
  input  logic       ClearCount,
  output logic [5:0] RAMaddress,
  output logic [6:0] RAMdata,
  output logic       RAMwrite,
  output logic [5:0] NumberOfChars,
  output logic       Receiving,
  output logic       Full,
  output logic       FrameError,
`ifdef UART_RX_PARITY_EN
  output logic       ParityError,
`endif
  output logic       Overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] C_FULL_BIT = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] C_HALF_BIT = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [5:0]    C_DEPTH    = 6'(DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WRITE     = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd6;
`endif

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_meta_q, rx_meta_d, rxs_q, rxs_d;
  logic [5:0]    count_q, count_d, addr_q, addr_d;
  logic [6:0]    data_q, data_d;
  logic          fe_q, fe_d, ovf_q, ovf_d;
  logic          tick, do_write, frame_ok;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d, pe_q, pe_d;
`endif

  assign tick = (baud_q == '0);

`ifdef UART_RX_PARITY_EN
  assign frame_ok = ~par_bad_q;
`else
  assign frame_ok = 1'b1;
`endif

  // Synchronizer resets to idle-high so reset release never looks like a start bit
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      count_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      fe_q      <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_meta_q <= rx_meta_d;
      rxs_q     <= rxs_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      fe_q      <= fe_d;
      ovf_q     <= ovf_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      pe_q      <= pe_d;
`endif
    end
  end

  always_comb begin
    rx_meta_d = rx;
    rxs_d     = rx_meta_q;
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          baud_d  = C_HALF_BIT;
        end
      end
      S_START: begin
        if (!tick) baud_d = baud_q - 1'b1;
        else if (!rxs_q) begin
          state_d = S_DATA;
          baud_d  = C_FULL_BIT;
          bit_d   = 3'd0;
        end else state_d = S_IDLE;
      end
      S_DATA: begin
        if (!tick) baud_d = baud_q - 1'b1;
        else begin
          shift_d = {rxs_q, shift_q[7:1]};
          baud_d  = C_FULL_BIT;
          bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!tick) baud_d = baud_q - 1'b1;
        else begin
          par_bad_d = ^{shift_q, rxs_q};
          baud_d    = C_FULL_BIT;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!tick) baud_d = baud_q - 1'b1;
        else if (!rxs_q) state_d = S_WAIT_HIGH;
        else if (frame_ok) state_d = S_WRITE;
        else state_d = S_IDLE;
      end
      S_WRITE:     state_d = S_IDLE;
      S_WAIT_HIGH: if (rxs_q) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Full          = (count_q == C_DEPTH);
    do_write      = (state_q == S_WRITE) && !Full && !ClearCount;
    RAMwrite      = do_write;
    RAMaddress    = do_write ? count_q : addr_q;
    RAMdata       = do_write ? shift_q[6:0] : data_q;
    NumberOfChars = count_q;
    Receiving     = (state_q != S_IDLE) && (state_q != S_WAIT_HIGH);
    FrameError    = fe_q;
    Overflow      = ovf_q;
`ifdef UART_RX_PARITY_EN
    ParityError   = pe_q;
`endif
  end

  // Count and sticky flags; a same-cycle clear overrides any update
  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    fe_d    = fe_q;
    ovf_d   = ovf_q;
`ifdef UART_RX_PARITY_EN
    pe_d    = pe_q;
    if (state_q == S_PARITY && tick && (^{shift_q, rxs_q})) pe_d = 1'b1;
`endif
    if (do_write) begin
      count_d = count_q + 6'd1;
      addr_d  = count_q;
      data_d  = shift_q[6:0];
    end
    if (state_q == S_WRITE && Full) ovf_d = 1'b1;
    if (state_q == S_STOP && tick && !rxs_q) fe_d = 1'b1;
    if (ClearCount) begin
      count_d = '0;
      fe_d    = 1'b0;
      ovf_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_d    = 1'b0;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ram_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_ram_loader: directed scoreboard bench for uart_rx_ram_loader   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_uart_rx_ram_loader;
  localparam int CPB = 16;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       rx;
  logic       ClearCount;
  logic [5:0] RAMaddress;
  logic [6:0] RAMdata;
  logic       RAMwrite;
  logic [5:0] NumberOfChars;
  logic       Receiving;
  logic       Full;
  logic       FrameError;
  logic       Overflow;
`ifdef UART_RX_PARITY_EN
  logic       ParityError;
`endif

  int tests = 0;
  int fails = 0;
  logic [12:0] exp_q[$];
  logic [12:0] exp_w;

  uart_rx_ram_loader #(
    .CLOCK_HZ(160000),
    .BAUD(10000),
    .DEPTH(4)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .rx(rx),
    .ClearCount(ClearCount),
    .RAMaddress(RAMaddress),
    .RAMdata(RAMdata),
    .RAMwrite(RAMwrite),
    .NumberOfChars(NumberOfChars),
    .Receiving(Receiving),
    .Full(Full),
    .FrameError(FrameError),
`ifdef UART_RX_PARITY_EN
    .ParityError(ParityError),
`endif
    .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest expected (address, data) pair
  always @(negedge Clock) begin
    if (RAMwrite === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write", {19'd0, RAMaddress, RAMdata}, 32'hFFFF_FFFF);
      else begin
        exp_w = exp_q.pop_front();
        check("write_addr_data", {19'd0, RAMaddress, RAMdata}, {19'd0, exp_w});
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge Clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge Clock);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge Clock);
    rx = 1'b1;
    repeat (4) @(negedge Clock);
  endtask

  task automatic send_ok(input logic [7:0] b, input logic [5:0] addr);
    exp_q.push_back({addr, b[6:0]});
    send_frame(b, 1'b1);
  endtask

  task automatic clear_pulse();
    ClearCount = 1'b1;
    @(negedge Clock);
    ClearCount = 1'b0;
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b1;
    rx = 1'b1;
    ClearCount = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset_outputs", {7'd0, RAMaddress, RAMdata, RAMwrite, NumberOfChars, Receiving, Full, FrameError, Overflow}, 32'd0);
    Reset = 1'b0;
    repeat (5) @(negedge Clock);

    send_ok(8'h41, 6'd0);
    send_ok(8'h62, 6'd1);
    check("count_after_two", {26'd0, NumberOfChars}, 32'd2);
    check("flags_after_two", {29'd0, FrameError, Overflow, Full}, 32'd0);

    send_ok(8'hC1, 6'd2);
    check("count_after_bit7", {26'd0, NumberOfChars}, 32'd3);

    // short low pulse must be rejected as a glitch
    rx = 1'b0;
    repeat (4) @(negedge Clock);
    check("glitch_receiving_high", {31'd0, Receiving}, 32'd1);
    @(negedge Clock);
    rx = 1'b1;
    repeat (30) @(negedge Clock);
    check("glitch_receiving_low", {31'd0, Receiving}, 32'd0);
    check("glitch_no_frame_error", {31'd0, FrameError}, 32'd0);
    check("glitch_count", {26'd0, NumberOfChars}, 32'd3);

    clear_pulse();
    check("clear_count", {26'd0, NumberOfChars}, 32'd0);
    send_frame(8'h33, 1'b0);
    repeat (20) @(negedge Clock);
    check("frame_error_set", {31'd0, FrameError}, 32'd1);
    check("frame_error_no_count", {26'd0, NumberOfChars}, 32'd0);
    send_ok(8'h34, 6'd0);
    check("count_after_recovery", {26'd0, NumberOfChars}, 32'd1);

    clear_pulse();
    check("clear_frame_error", {31'd0, FrameError}, 32'd0);
    for (int i = 0; i < 4; i++) send_ok(8'h30 + 8'(i), 6'(i));
    check("full_no_overflow", {30'd0, Full, Overflow}, 32'b10);
    send_frame(8'h39, 1'b1);
    check("full_flag", {31'd0, Full}, 32'd1);
    check("overflow_flag", {31'd0, Overflow}, 32'd1);
    check("count_saturated", {26'd0, NumberOfChars}, 32'd4);
    clear_pulse();
    check("clear_full_overflow", {26'd0, NumberOfChars, Full, Overflow}, 32'd0);
    send_ok(8'h5A, 6'd0);
    check("after_clear_full", {31'd0, Full}, 32'd0);
    check("after_clear_count", {26'd0, NumberOfChars}, 32'd1);

    // reset in the middle of the data bits of 0x55
    rx = 1'b0;
    repeat (CPB) @(negedge Clock);
    for (int i = 0; i < 3; i++) begin
      rx = (i % 2 == 0) ? 1'b1 : 1'b0;
      repeat (CPB) @(negedge Clock);
    end
    check("midframe_receiving", {31'd0, Receiving}, 32'd1);
    Reset = 1'b1;
    rx = 1'b1;
    #1;
    check("midframe_reset_outputs", {7'd0, RAMaddress, RAMdata, RAMwrite, NumberOfChars, Receiving, Full, FrameError, Overflow}, 32'd0);
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    repeat (10) @(negedge Clock);
    send_ok(8'h21, 6'd0);
    check("count_after_reset_frame", {26'd0, NumberOfChars}, 32'd1);

    repeat (10) @(negedge Clock);
    check("all_writes_seen", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL timeout tests=%0d", tests);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
